// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg -- shared types and constants for the serial instruction loader.
//   state_t    : loader FSM states (CHECK is used only when parity is compiled in)
//   DEF_IW     : default instruction width
//   DEF_DEPTH  : default FIFO depth
//   clog2()    : ceiling log2 usable in parameter/port width expressions
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int DEF_IW    = 9;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if -- serial input, downstream handshake and status flags of instr_loader.
//   SDI/SVALID/SFRAME : serial instruction stream (MSB first)
//   READY             : downstream accepts the head instruction
//   CLR               : synchronous clear of the sticky flags
//   INSTRUCTION/write_en/LEVEL : FIFO head, head-valid, occupancy
//   OVF/PERR          : sticky overflow / parity-error flags
// Modports: master = stimulus/downstream side, slave = instr_loader.
interface instr_loader_if
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = DEF_IW
);
    localparam int LW = clog2(DEPTH + 1);

    logic          SDI;
    logic          SVALID;
    logic          SFRAME;
    logic          READY;
    logic          CLR;
    logic [IW-1:0] INSTRUCTION;
    logic          write_en;
    logic [LW-1:0] LEVEL;
    logic          OVF;
    logic          PERR;

    modport master (
        output SDI, SVALID, SFRAME, READY, CLR,
        input  INSTRUCTION, write_en, LEVEL, OVF, PERR
    );

    modport slave (
        input  SDI, SVALID, SFRAME, READY, CLR,
        output INSTRUCTION, write_en, LEVEL, OVF, PERR
    );

endinterface

// File: rtl/instr_loader_fifo.sv
// instr_fifo -- DEPTH-entry instruction FIFO with occupancy counter.
//   clk, rst : clock, asynchronous active-high reset (pointers/level only)
//   push/din : write request and data; accepted when not full or when popping
//   pop      : read request; ignored while empty
//   dout     : head entry, forced to 0 while empty
//   full, empty, level : status
module instr_fifo
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = DEF_IW,
    localparam int PW   = clog2(DEPTH),
    localparam int LW   = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [IW-1:0] din,
    input  logic          pop,
    output logic [IW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok, push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still take a push.
    assign push_ok = push && (!full || pop_ok);
    // Storage is not reset; masking with empty keeps stale entries invisible.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers are PW bits and DEPTH is a power of two, so +1 wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader -- deserialises MSB-first instruction words into a FIFO for the cpu.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : instr_loader_if.slave (serial in, READY/CLR in, head/level/flags out)
// Optional feature: define INSTR_LOADER_PARITY_EN to append an even-parity bit
// to each word; bad words are dropped and PERR is set. Without it PERR is 0.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = DEF_IW
) (
    input  logic           CLK,
    input  logic           RESET,
    instr_loader_if.slave  bus
);
    localparam int CW = clog2(IW + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] sreg;
    logic [IW-1:0] word;
    logic          push, full, empty, ovf, ovf_set;

    wire sample = bus.SVALID && bus.SFRAME;

`ifdef INSTR_LOADER_PARITY_EN
    logic par_err, perr;

    // The data word is already whole in sreg; this edge carries its parity bit.
    always_comb begin
        push    = 1'b0;
        par_err = 1'b0;
        word    = sreg;
        if (sample && state == CHECK) begin
            if (^{sreg, bus.SDI}) par_err = 1'b1;
            else                  push    = 1'b1;
        end
    end
    assign bus.PERR = perr;
`else
    // The word completes on the edge that samples its last bit.
    always_comb begin
        push = sample && (state == SHIFT) && (cnt == CW'(IW - 1));
        word = {sreg[IW-2:0], bus.SDI};
    end
    assign bus.PERR = 1'b0;
`endif

    assign ovf_set = push && full && !(bus.READY && !empty);
    assign bus.write_en = !empty;
    assign bus.OVF      = ovf;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            ovf   <= 1'b0;
`ifdef INSTR_LOADER_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            // Losing the frame mid-word silently discards the partial word.
            if (!bus.SFRAME) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (bus.SVALID) begin
                case (state)
                    IDLE: begin
                        sreg  <= {sreg[IW-2:0], bus.SDI};
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        sreg <= {sreg[IW-2:0], bus.SDI};
                        if (cnt == CW'(IW - 1)) begin
`ifdef INSTR_LOADER_PARITY_EN
                            state <= CHECK;
                            cnt   <= CW'(IW);
`else
                            state <= IDLE;
                            cnt   <= '0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            // CLR wins over a set on the same edge.
            if (bus.CLR) begin
                ovf <= 1'b0;
`ifdef INSTR_LOADER_PARITY_EN
                perr <= 1'b0;
`endif
            end else begin
                if (ovf_set) ovf <= 1'b1;
`ifdef INSTR_LOADER_PARITY_EN
                if (par_err) perr <= 1'b1;
`endif
            end
        end
    end

    instr_fifo #(.DEPTH(DEPTH), .IW(IW)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .din   (word),
        .pop   (bus.READY),
        .dout  (bus.INSTRUCTION),
        .full  (full),
        .empty (empty),
        .level (bus.LEVEL)
    );

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader -- directed table-driven bench for instr_loader (DEPTH=4, IW=9).
module tb_instr_loader;
    localparam int DEPTH = 4;
    localparam int IW    = 9;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    instr_loader_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

    instr_loader #(.DEPTH(DEPTH), .IW(IW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam int OP_SEND = 0;
    localparam int OP_POP  = 1;
    localparam int OP_CLR  = 2;

    typedef struct {
        int          op;
        logic [8:0]  data;
        logic        rdy;
        logic [8:0]  e_instr;
        logic        e_we;
        logic [2:0]  e_lvl;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] instr, input logic we,
                           input logic [2:0] lvl, input logic ovf);
        chk({tag, " INSTRUCTION"}, 32'(bus.INSTRUCTION), 32'(instr));
        chk({tag, " write_en"},    32'(bus.write_en),    32'(we));
        chk({tag, " LEVEL"},       32'(bus.LEVEL),       32'(lvl));
        chk({tag, " OVF"},         32'(bus.OVF),         32'(ovf));
    endtask

    task automatic idle_inputs();
        bus.SDI = 1'b0; bus.SVALID = 1'b0; bus.SFRAME = 1'b0;
        bus.READY = 1'b0; bus.CLR = 1'b0;
    endtask

    // Shift one word MSB-first; READY is raised only on the final serial edge.
    task automatic send_word(input logic [8:0] w, input logic rdy, input logic flip);
        int nb;
        nb = IW;
`ifdef INSTR_LOADER_PARITY_EN
        nb = IW + 1;
`endif
        for (int i = 0; i < IW; i++) begin
            @(negedge CLK);
            bus.SVALID = 1'b1; bus.SFRAME = 1'b1; bus.SDI = w[IW-1-i];
            bus.READY  = rdy && (i == nb - 1);
        end
`ifdef INSTR_LOADER_PARITY_EN
        @(negedge CLK);
        bus.SDI = (^w) ^ flip; bus.READY = rdy;
`else
        if (flip) bus.SDI = bus.SDI;
`endif
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic pulse_ready();
        @(negedge CLK); bus.READY = 1'b1;
        @(negedge CLK); bus.READY = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge CLK); bus.CLR = 1'b1;
        @(negedge CLK); bus.CLR = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_SEND, 9'h1A5, 1'b0, 9'h1A5, 1'b1, 3'd1, 1'b0};
        vecs[1]  = '{OP_SEND, 9'h0AA, 1'b0, 9'h1A5, 1'b1, 3'd2, 1'b0};
        vecs[2]  = '{OP_SEND, 9'h155, 1'b0, 9'h1A5, 1'b1, 3'd3, 1'b0};
        vecs[3]  = '{OP_SEND, 9'h0F0, 1'b0, 9'h1A5, 1'b1, 3'd4, 1'b0};
        vecs[4]  = '{OP_SEND, 9'h111, 1'b0, 9'h1A5, 1'b1, 3'd4, 1'b1};
        vecs[5]  = '{OP_CLR,  9'h000, 1'b0, 9'h1A5, 1'b1, 3'd4, 1'b0};
        vecs[6]  = '{OP_SEND, 9'h077, 1'b1, 9'h0AA, 1'b1, 3'd4, 1'b0};
        vecs[7]  = '{OP_POP,  9'h000, 1'b1, 9'h155, 1'b1, 3'd3, 1'b0};
        vecs[8]  = '{OP_POP,  9'h000, 1'b1, 9'h0F0, 1'b1, 3'd2, 1'b0};
        vecs[9]  = '{OP_POP,  9'h000, 1'b1, 9'h077, 1'b1, 3'd1, 1'b0};
        vecs[10] = '{OP_POP,  9'h000, 1'b1, 9'h000, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{OP_POP,  9'h000, 1'b1, 9'h000, 1'b0, 3'd0, 1'b0};
        vecs[12] = '{OP_SEND, 9'h0C3, 1'b0, 9'h0C3, 1'b1, 3'd1, 1'b0};
        vecs[13] = '{OP_SEND, 9'h1FF, 1'b1, 9'h1FF, 1'b1, 3'd1, 1'b0};
        vecs[14] = '{OP_POP,  9'h000, 1'b1, 9'h000, 1'b0, 3'd0, 1'b0};

        idle_inputs();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk_all("reset", 9'h000, 1'b0, 3'd0, 1'b0);
        chk("reset PERR", 32'(bus.PERR), 32'd0);

        for (int v = 0; v < 15; v++) begin
            case (vecs[v].op)
                OP_SEND: send_word(vecs[v].data, vecs[v].rdy, 1'b0);
                OP_POP:  pulse_ready();
                default: pulse_clr();
            endcase
            chk_all($sformatf("vec%0d", v), vecs[v].e_instr, vecs[v].e_we,
                    vecs[v].e_lvl, vecs[v].e_ovf);
        end

        // Frame lost after 5 bits; a stray SVALID without SFRAME is ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.SVALID = 1'b1; bus.SFRAME = 1'b1; bus.SDI = 1'b1;
        end
        @(negedge CLK);
        bus.SFRAME = 1'b0; bus.SVALID = 1'b1; bus.SDI = 1'b1;
        @(negedge CLK);
        idle_inputs();
        chk("abort LEVEL", 32'(bus.LEVEL), 32'd0);
        send_word(9'h003, 1'b0, 1'b0);
        chk_all("abort", 9'h003, 1'b1, 3'd1, 1'b0);
        pulse_ready();
        chk_all("abort drain", 9'h000, 1'b0, 3'd0, 1'b0);

`ifdef INSTR_LOADER_PARITY_EN
        send_word(9'h0FF, 1'b0, 1'b1);
        chk_all("par bad", 9'h000, 1'b0, 3'd0, 1'b0);
        chk("par bad PERR", 32'(bus.PERR), 32'd1);
        pulse_clr();
        chk("par clr PERR", 32'(bus.PERR), 32'd0);
        send_word(9'h0FF, 1'b0, 1'b0);
        chk_all("par good", 9'h0FF, 1'b1, 3'd1, 1'b0);
        chk("par good PERR", 32'(bus.PERR), 32'd0);
        pulse_ready();
`endif

        // Asynchronous reset in the middle of a word with three stored.
        send_word(9'h101, 1'b0, 1'b0);
        send_word(9'h102, 1'b0, 1'b0);
        send_word(9'h103, 1'b0, 1'b0);
        chk_all("pre-reset", 9'h101, 1'b1, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bus.SVALID = 1'b1; bus.SFRAME = 1'b1; bus.SDI = i[0];
        end
        #2 RESET = 1'b1;
        #1;
        chk_all("async reset", 9'h000, 1'b0, 3'd0, 1'b0);
        @(negedge CLK);
        idle_inputs();
        RESET = 1'b0;
        send_word(9'h1A5, 1'b0, 1'b0);
        chk_all("post-reset", 9'h1A5, 1'b1, 3'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter IW, default 9, the instruction width in bits.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 SDI  input  1  serial instruction data, MSB first.
REQ-006 SVALID  input  1  SDI is sampled on a CLK rising edge only when SVALID=1.
REQ-007 SFRAME  input  1  word framing; must be high for every bit of a word.
REQ-008 READY  input  1  the downstream cpu accepts the head instruction this cycle.
REQ-009 CLR  input  1  synchronous clear of the sticky flags.
REQ-010 INSTRUCTION  output  IW  the head FIFO entry; 0 when the FIFO is empty.
REQ-011 write_en  output  1  the head entry is valid (FIFO not empty).
REQ-012 LEVEL  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 OVF  output  1  sticky flag: a completed word was dropped because the FIFO was full.
REQ-014 PERR  output  1  sticky flag: parity error (0 when parity is compiled out).

Function
REQ-015 States SHALL be IDLE, SHIFT and (with parity) CHECK.
- IDLE->SHIFT on the first sampled bit with SFRAME=1.
- SHIFT->IDLE after bit IW-1 (no parity) or after bit IW (parity).
REQ-016 A sampled bit SHALL shift into a holding register MSB-first, and a bit counter SHALL increment from 0 to IW-1.
REQ-017 A word SHALL complete on the edge that samples its last bit; it is pushed on that same edge and is visible on INSTRUCTION/write_en the next cycle (latency 1 after the last bit).
REQ-018 If SFRAME falls while the counter is non-zero, the partial word SHALL be discarded and the state SHALL return to IDLE with no flag set.
REQ-019 Bits with SFRAME=0 and SVALID=1 SHALL be ignored.
REQ-020 A pop SHALL occur on an edge where write_en=1 and READY=1; READY while the FIFO is empty has no effect.
REQ-021 Full FIFO with a completing word:
- with a simultaneous pop, the push is accepted and LEVEL is unchanged;
- otherwise the word is dropped, OVF sets, and the contents are unchanged.
REQ-022 Simultaneous push and pop at any non-full level SHALL leave LEVEL unchanged.
REQ-023 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-024 CLR SHALL clear OVF and PERR.
- CLR has priority over a same-cycle set.
- CLR does not affect the FIFO or the shifter.

Reset
REQ-025 RESET SHALL asynchronously force:
- state=IDLE, bit counter=0, pointers=0;
- LEVEL=0, write_en=0, INSTRUCTION=0, OVF=0, PERR=0.
REQ-026 Reset mid-word or mid-handshake SHALL discard all stored and partial words; FIFO contents need not be cleared, as long as they are not observable.

Configuration
REQ-027 With INSTR_LOADER_PARITY_EN defined, each word SHALL carry one extra trailing even-parity bit.
- The CHECK state compares it.
- Mismatch: the word is dropped and PERR sets.
- Match: the word is pushed on the parity-bit edge.
REQ-028 Without INSTR_LOADER_PARITY_EN, words SHALL be IW bits, CHECK SHALL not exist, and PERR SHALL be tied to 0.

Structure
REQ-029 A shared package SHALL hold:
- the state enum (IDLE, SHIFT, CHECK);
- the default IW=9 and DEPTH=4 constants;
- a clog2 helper function.
REQ-030 The FIFO storage and pointers SHALL be a sub-module named instr_fifo, with push/pop/full/empty/level; the serial shifter and FSM stay in instr_loader.

Verification
REQ-031 Reset, then shift 9'h1A5 MSB-first with SFRAME=1 and READY=0 -> next cycle write_en=1, INSTRUCTION=9'h1A5, LEVEL=1.
REQ-032 Push 5 words (DEPTH=4) with READY=0 -> first 4 retained in order, 5th dropped, OVF=1, LEVEL=4; CLR pulse -> OVF=0.
REQ-033 FIFO full, last bit of a new word sampled with READY=1 -> push accepted, LEVEL stays 4, and the popped word is the oldest.
REQ-034 SFRAME dropped after 5 bits, then 9'h003 sent -> only 9'h003 appears, LEVEL=1, OVF=0.
REQ-035 With INSTR_LOADER_PARITY_EN, send 9'h0FF with parity bit 1 -> dropped, PERR=1, LEVEL=0; send 9'h0FF with parity bit 0 -> accepted.
REQ-036 RESET asserted asynchronously mid-word with LEVEL=3 -> immediately write_en=0, LEVEL=0, INSTRUCTION=0; after release a fresh word loads correctly.
